// File: rtl/systolic_mac_cell_pkg.sv
// Shared types, defaults and saturating add for the systolic MAC cell.
// SYSTOLIC_MAC_SAT_EN selects clamped arithmetic in systolic_mac_pipe.
package systolic_pkg;

  localparam int DATA_W_DEFAULT      = 16;
  localparam int ACC_W_DEFAULT       = 40;
  localparam int SYS_MAC_LAT_DEFAULT = 3;
  localparam int SUM_W               = ACC_W_DEFAULT + 1;

  typedef logic signed [DATA_W_DEFAULT-1:0] data_t;
  typedef logic signed [ACC_W_DEFAULT-1:0]  acc_t;

  // Adds two values that are sign-extended from 'width' bits and clamps the
  // result to the signed range of 'width' bits. width must not exceed ACC_W_DEFAULT.
  function automatic acc_t sat_add(input acc_t a, input acc_t b, input int width,
                                   output logic ovf);
    logic signed [SUM_W-1:0] full;
    logic signed [SUM_W-1:0] hi;
    logic signed [SUM_W-1:0] lo;
    acc_t                    res;
    full = {a[ACC_W_DEFAULT-1], a} + {b[ACC_W_DEFAULT-1], b};
    hi   = (SUM_W'(1) << (width - 1)) - SUM_W'(1);
    lo   = -hi - SUM_W'(1);
    ovf  = 1'b0;
    res  = full[ACC_W_DEFAULT-1:0];
    if (full > hi) begin
      res = hi[ACC_W_DEFAULT-1:0];
      ovf = 1'b1;
    end else if (full < lo) begin
      res = lo[ACC_W_DEFAULT-1:0];
      ovf = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/systolic_mac_cell_if.sv
// Data, partial-sum, weight-chain and swap signals of one processing element.
// The cell itself uses the slave modport; whoever drives the cell uses master.
interface systolic_mac_cell_if #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
);
  logic                     enable;
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic signed [ACC_W-1:0]  in_sum;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_dvalid;
  logic signed [ACC_W-1:0]  out_sum;
  logic                     out_ovf;
  logic                     w_in_valid;
  logic signed [DATA_W-1:0] w_in;
  logic                     w_out_valid;
  logic signed [DATA_W-1:0] w_out;
  logic                     swap_in;
  logic                     swap_out;

  modport slave (
    input  enable, in_valid, in_data, in_sum, w_in_valid, w_in, swap_in,
    output out_valid, out_data, out_dvalid, out_sum, out_ovf, w_out_valid, w_out, swap_out
  );

  modport master (
    output enable, in_valid, in_data, in_sum, w_in_valid, w_in, swap_in,
    input  out_valid, out_data, out_dvalid, out_sum, out_ovf, w_out_valid, w_out, swap_out
  );
endinterface

// File: rtl/systolic_mac_cell_pipe.sv
// Multiply-add with a MAC_LAT-deep result/valid/overflow delay line.
// Stage 0 registers the operands and the weight that was active when they
// were sampled; the sum is formed from those registers and delayed MAC_LAT-1 more.
// SYSTOLIC_MAC_SAT_EN: clamp to the ACC_W range and flag clamped valid results.
module systolic_mac_pipe
  import systolic_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int ACC_W   = ACC_W_DEFAULT,
  parameter int MAC_LAT = SYS_MAC_LAT_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic signed [DATA_W-1:0] weight,
  input  logic signed [ACC_W-1:0]  in_sum,
  output logic                     out_valid,
  output logic signed [ACC_W-1:0]  out_sum,
  output logic                     out_ovf
);

  logic                       s0_valid;
  logic signed [DATA_W-1:0]   s0_data;
  logic signed [DATA_W-1:0]   s0_w;
  logic signed [ACC_W-1:0]    s0_sum;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    mac_sum;
  logic                       mac_ovf;

  // Stage 0: capture operands together with the weight active at sampling time
  always_ff @(posedge clk) begin
    if (reset) begin
      s0_valid <= 1'b0;
      s0_data  <= '0;
      s0_w     <= '0;
      s0_sum   <= '0;
    end else if (enable) begin
      s0_valid <= in_valid;
      s0_data  <= in_data;
      s0_w     <= weight;
      s0_sum   <= in_sum;
    end
  end

  assign prod     = (2*DATA_W)'(s0_data) * (2*DATA_W)'(s0_w);
  assign prod_ext = ACC_W'(prod);

`ifdef SYSTOLIC_MAC_SAT_EN
  acc_t sat_res;
  logic clamp;

  // Clamped multiply-add; overflow is only reported for valid results
  always_comb begin
    clamp   = 1'b0;
    sat_res = sat_add(acc_t'(s0_sum), acc_t'(prod_ext), ACC_W, clamp);
    mac_sum = sat_res[ACC_W-1:0];
    mac_ovf = s0_valid & clamp;
  end
`else
  // Wrap-around multiply-add; overflow never reported
  always_comb begin
    mac_sum = s0_sum + prod_ext;
    mac_ovf = 1'b0;
  end
`endif

  if (MAC_LAT > 1) begin : g_dly
    localparam int N = MAC_LAT - 1;
    logic                    d_valid [N];
    logic signed [ACC_W-1:0] d_sum   [N];
    logic                    d_ovf   [N];

    // Result delay line; reset drops anything in flight
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < N; i++) begin
          d_valid[i] <= 1'b0;
          d_sum[i]   <= '0;
          d_ovf[i]   <= 1'b0;
        end
      end else if (enable) begin
        d_valid[0] <= s0_valid;
        d_sum[0]   <= mac_sum;
        d_ovf[0]   <= mac_ovf;
        for (int i = 1; i < N; i++) begin
          d_valid[i] <= d_valid[i-1];
          d_sum[i]   <= d_sum[i-1];
          d_ovf[i]   <= d_ovf[i-1];
        end
      end
    end

    assign out_valid = d_valid[N-1];
    assign out_sum   = d_sum[N-1];
    assign out_ovf   = d_ovf[N-1];
  end else begin : g_nodly
    assign out_valid = s0_valid;
    assign out_sum   = mac_sum;
    assign out_ovf   = mac_ovf;
  end

endmodule

// File: rtl/systolic_mac_cell.sv
// Weight-stationary systolic processing element.
// Holds the east data register, the shadow/active weight pair and the
// weight-chain / swap ripple registers; the MAC itself lives in systolic_mac_pipe.
// SYSTOLIC_MAC_SAT_EN (see systolic_mac_pipe) selects saturating arithmetic.
module systolic_mac_cell
  import systolic_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int ACC_W   = ACC_W_DEFAULT,
  parameter int MAC_LAT = SYS_MAC_LAT_DEFAULT
) (
  input logic                clk,
  input logic                reset,
  systolic_mac_cell_if.slave bus
);

  logic signed [DATA_W-1:0] shadow_w;
  logic signed [DATA_W-1:0] active_w;
  logic signed [DATA_W-1:0] data_q;
  logic                     dvalid_q;
  logic signed [DATA_W-1:0] w_out_q;
  logic                     w_out_valid_q;
  logic                     swap_q;

  // East data register, weight double buffer and chain/swap ripple.
  // Swap reads the pre-load shadow, so a simultaneous load and swap
  // activates the old shadow while the new weight lands in the shadow.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_w      <= '0;
      active_w      <= '0;
      data_q        <= '0;
      dvalid_q      <= 1'b0;
      w_out_q       <= '0;
      w_out_valid_q <= 1'b0;
      swap_q        <= 1'b0;
    end else if (bus.enable) begin
      data_q   <= bus.in_data;
      dvalid_q <= bus.in_valid;
      swap_q   <= bus.swap_in;
      if (bus.swap_in) active_w <= shadow_w;
      if (bus.w_in_valid) begin
        shadow_w      <= bus.w_in;
        w_out_q       <= shadow_w;
        w_out_valid_q <= 1'b1;
      end else begin
        w_out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_data    = data_q;
  assign bus.out_dvalid  = dvalid_q;
  assign bus.w_out       = w_out_q;
  assign bus.w_out_valid = w_out_valid_q;
  assign bus.swap_out    = swap_q;

  systolic_mac_pipe #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .MAC_LAT(MAC_LAT)
  ) u_pipe (
    .clk      (clk),
    .reset    (reset),
    .enable   (bus.enable),
    .in_valid (bus.in_valid),
    .in_data  (bus.in_data),
    .weight   (active_w),
    .in_sum   (bus.in_sum),
    .out_valid(bus.out_valid),
    .out_sum  (bus.out_sum),
    .out_ovf  (bus.out_ovf)
  );

endmodule

// File: tb/tb_systolic_mac_cell.sv
// Self-checking bench for systolic_mac_cell: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_systolic_mac_cell;

  localparam int DW   = 16;
  localparam int AW   = 40;
  localparam int AW32 = 32;
  localparam int LAT  = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  systolic_mac_cell_if #(.DATA_W(DW), .ACC_W(AW)) d_if ();
  systolic_mac_cell #(.DATA_W(DW), .ACC_W(AW), .MAC_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .bus(d_if));

  systolic_mac_cell_if #(.DATA_W(DW), .ACC_W(AW32)) n_if ();
  systolic_mac_cell #(.DATA_W(DW), .ACC_W(AW32), .MAC_LAT(LAT)) dut32 (
    .clk(clk), .reset(reset), .bus(n_if));

  // Four-cell weight chain
  systolic_mac_cell_if #(.DATA_W(DW), .ACC_W(AW)) ch_if [4] ();
  logic                 ch_iv = 1'b0;
  logic signed [DW-1:0] ch_w_in = '0;
  logic                 ch_wiv = 1'b0;
  logic                 ch_swap = 1'b0;
  logic signed [AW-1:0] ch_sum [4];
  logic                 ch_ov  [4];
  logic                 ch_so  [4];

  for (genvar k = 0; k < 4; k++) begin : g_ch
    systolic_mac_cell #(.DATA_W(DW), .ACC_W(AW), .MAC_LAT(LAT)) u_cell (
      .clk(clk), .reset(reset), .bus(ch_if[k]));
    assign ch_if[k].enable   = 1'b1;
    assign ch_if[k].in_valid = ch_iv;
    assign ch_if[k].in_data  = 16'sd1;
    assign ch_if[k].in_sum   = '0;
    assign ch_sum[k] = ch_if[k].out_sum;
    assign ch_ov[k]  = ch_if[k].out_valid;
    assign ch_so[k]  = ch_if[k].swap_out;
    if (k == 0) begin : g_head
      assign ch_if[k].w_in       = ch_w_in;
      assign ch_if[k].w_in_valid = ch_wiv;
      assign ch_if[k].swap_in    = ch_swap;
    end else begin : g_link
      assign ch_if[k].w_in       = ch_if[k-1].w_out;
      assign ch_if[k].w_in_valid = ch_if[k-1].w_out_valid;
      assign ch_if[k].swap_in    = ch_if[k-1].swap_out;
    end
  end

  typedef struct {
    int          issue;
    logic [AW-1:0] sum;
    logic        ovf;
  } exp_t;

  // in_sum + data*weight, wrapped or clamped to aw bits (low bits are the answer)
  function automatic logic [63:0] ref_mac(input longint s, input longint d, input longint w,
                                          input int aw, output logic ovf);
    longint full;
    full = s + d * w;
    ovf  = 1'b0;
`ifdef SYSTOLIC_MAC_SAT_EN
    begin
      longint hi, lo;
      hi = (longint'(1) <<< (aw - 1)) - 1;
      lo = -hi - 1;
      if (full > hi) begin full = hi; ovf = 1'b1; end
      else if (full < lo) begin full = lo; ovf = 1'b1; end
    end
`endif
    return full;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_main();
    d_if.enable = 1'b1; d_if.in_valid = 1'b0; d_if.in_data = '0; d_if.in_sum = '0;
    d_if.w_in_valid = 1'b0; d_if.w_in = '0; d_if.swap_in = 1'b0;
  endtask

  task automatic idle_n();
    n_if.enable = 1'b1; n_if.in_valid = 1'b0; n_if.in_data = '0; n_if.in_sum = '0;
    n_if.w_in_valid = 1'b0; n_if.w_in = '0; n_if.swap_in = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    d_if.enable = 1'b1; d_if.in_valid = 1'b1; d_if.in_data = 16'sh1234; d_if.in_sum = 40'sh55;
    d_if.w_in_valid = 1'b1; d_if.w_in = 16'sh7; d_if.swap_in = 1'b1;
    idle_n();
    tick(); tick();
    total++; if (d_if.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got %0h want 0", d_if.out_valid); end
    total++; if (d_if.out_data !== '0) begin bad++; $display("FAIL rst_out_data got %0h want 0", d_if.out_data); end
    total++; if (d_if.out_dvalid !== 1'b0) begin bad++; $display("FAIL rst_out_dvalid got %0h want 0", d_if.out_dvalid); end
    total++; if (d_if.out_sum !== '0) begin bad++; $display("FAIL rst_out_sum got %0h want 0", d_if.out_sum); end
    total++; if (d_if.out_ovf !== 1'b0) begin bad++; $display("FAIL rst_out_ovf got %0h want 0", d_if.out_ovf); end
    total++; if (d_if.w_out_valid !== 1'b0) begin bad++; $display("FAIL rst_w_out_valid got %0h want 0", d_if.w_out_valid); end
    total++; if (d_if.w_out !== '0) begin bad++; $display("FAIL rst_w_out got %0h want 0", d_if.w_out); end
    total++; if (d_if.swap_out !== 1'b0) begin bad++; $display("FAIL rst_swap_out got %0h want 0", d_if.swap_out); end
    reset = 1'b0;
    idle_main();
    tick();
  endtask

  task automatic test_basic();
    d_if.w_in = 16'sd3; d_if.w_in_valid = 1'b1;
    tick();
    total++; if (d_if.w_out_valid !== 1'b1 || d_if.w_out !== 16'sd0) begin bad++;
      $display("FAIL basic_wload got v=%0h w=%0h want v=1 w=0", d_if.w_out_valid, d_if.w_out); end
    d_if.w_in_valid = 1'b0; d_if.swap_in = 1'b1;
    tick();
    total++; if (d_if.swap_out !== 1'b1 || d_if.w_out_valid !== 1'b0) begin bad++;
      $display("FAIL basic_swap got so=%0h wv=%0h want so=1 wv=0", d_if.swap_out, d_if.w_out_valid); end
    d_if.swap_in = 1'b0; d_if.in_valid = 1'b1; d_if.in_data = 16'sd5; d_if.in_sum = 40'sd7;
    tick();
    idle_main();
    total++; if (d_if.out_dvalid !== 1'b1 || d_if.out_data !== 16'sd5 || d_if.out_valid !== 1'b0) begin bad++;
      $display("FAIL basic_east got dv=%0h d=%0h ov=%0h want dv=1 d=5 ov=0", d_if.out_dvalid, d_if.out_data, d_if.out_valid); end
    tick();
    total++; if (d_if.out_valid !== 1'b0 || d_if.out_dvalid !== 1'b0) begin bad++;
      $display("FAIL basic_lat2 got ov=%0h dv=%0h want 0 0", d_if.out_valid, d_if.out_dvalid); end
    tick();
    total++; if (d_if.out_valid !== 1'b1 || d_if.out_sum !== 40'sd22 || d_if.out_ovf !== 1'b0) begin bad++;
      $display("FAIL basic_sum got ov=%0h sum=%0h ovf=%0h want 1 22 0", d_if.out_valid, d_if.out_sum, d_if.out_ovf); end
    tick();
    total++; if (d_if.out_valid !== 1'b0) begin bad++; $display("FAIL basic_after got ov=%0h want 0", d_if.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic signed [AW-1:0] got[$];
    d_if.w_in = 16'sd2; d_if.w_in_valid = 1'b1; tick();
    d_if.w_in_valid = 1'b0; d_if.swap_in = 1'b1; tick();
    d_if.swap_in = 1'b0; d_if.w_in = 16'sd9; d_if.w_in_valid = 1'b1; tick();
    d_if.w_in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      d_if.in_valid = 1'b1; d_if.in_data = 16'sd1; d_if.in_sum = AW'(100 * i);
      d_if.swap_in = (i == 4);
      tick();
      if (d_if.out_valid) got.push_back(d_if.out_sum);
    end
    idle_main();
    for (int i = 0; i < 10; i++) begin
      tick();
      if (d_if.out_valid) got.push_back(d_if.out_sum);
    end
    total++; if (got.size() != 8) begin bad++; $display("FAIL b2b_count got %0d want 8", got.size()); end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      total++;
      if (got[i] !== AW'(100 * i + ((i <= 4) ? 2 : 9))) begin bad++;
        $display("FAIL b2b_op%0d got %0d want %0d", i, got[i], 100 * i + ((i <= 4) ? 2 : 9)); end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      d_if.in_valid = 1'b1; d_if.in_data = DW'(i + 1); d_if.in_sum = AW'(1000 * i);
      tick();
    end
    d_if.enable = 1'b0; d_if.in_data = 16'sd77; d_if.in_sum = 40'sd5;
    d_if.w_in_valid = 1'b1; d_if.w_in = 16'sd13; d_if.swap_in = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      total++;
      if (d_if.out_valid !== 1'b1 || d_if.out_sum !== 40'sd9 || d_if.out_data !== 16'sd3 ||
          d_if.out_dvalid !== 1'b1 || d_if.w_out_valid !== 1'b0 || d_if.swap_out !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold%0d got ov=%0h sum=%0d d=%0d dv=%0h wv=%0h so=%0h want 1 9 3 1 0 0", c,
                 d_if.out_valid, d_if.out_sum, d_if.out_data, d_if.out_dvalid, d_if.w_out_valid, d_if.swap_out);
      end
    end
    idle_main();
    tick();
    total++; if (d_if.out_valid !== 1'b1 || d_if.out_sum !== 40'sd1018) begin bad++;
      $display("FAIL stall_resume1 got ov=%0h sum=%0d want 1 1018", d_if.out_valid, d_if.out_sum); end
    tick();
    total++; if (d_if.out_valid !== 1'b1 || d_if.out_sum !== 40'sd2027) begin bad++;
      $display("FAIL stall_resume2 got ov=%0h sum=%0d want 1 2027", d_if.out_valid, d_if.out_sum); end
    tick();
    total++; if (d_if.out_valid !== 1'b0) begin bad++; $display("FAIL stall_drain got ov=%0h want 0", d_if.out_valid); end
    d_if.in_valid = 1'b1; d_if.in_data = 16'sd1; d_if.in_sum = '0;
    tick();
    idle_main();
    tick(); tick();
    total++; if (d_if.out_valid !== 1'b1 || d_if.out_sum !== 40'sd9) begin bad++;
      $display("FAIL stall_weight got ov=%0h sum=%0d want 1 9", d_if.out_valid, d_if.out_sum); end
  endtask

  // Each cell forwards the value it held before every load, so the stream a
  // cell sees is its upstream neighbour's stream delayed by one load.
  task automatic test_chain();
    int seq[4] = '{4, 3, 2, 1};
    int recv[4][4];
    int exp_sh[4];
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 4; i++)
        recv[k][i] = (k == 0) ? seq[i] : ((i == 0) ? 0 : recv[k-1][i-1]);
    for (int k = 0; k < 4; k++) exp_sh[k] = recv[k][3];
    for (int i = 0; i < 4; i++) begin
      ch_wiv = 1'b1; ch_w_in = DW'(seq[i]);
      tick();
    end
    ch_wiv = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    ch_swap = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      tick();
      ch_swap = 1'b0;
      for (int k = 0; k < 4; k++) begin
        total++;
        if (ch_so[k] !== (j == k + 1)) begin bad++;
          $display("FAIL chain_swap c%0d t%0d got %0h want %0h", k, j, ch_so[k], (j == k + 1)); end
      end
    end
    ch_iv = 1'b1;
    tick();
    ch_iv = 1'b0;
    tick(); tick();
    for (int k = 0; k < 4; k++) begin
      total++;
      if (ch_ov[k] !== 1'b1 || ch_sum[k] !== AW'(exp_sh[k])) begin bad++;
        $display("FAIL chain_weight c%0d got ov=%0h sum=%0d want 1 %0d", k, ch_ov[k], ch_sum[k], exp_sh[k]); end
    end
  endtask

  task automatic test_overflow();
    logic [AW32-1:0] cs[4] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFE, 32'hFFFF_FFFB};
    int              cd[4] = '{1, -1, 1, 3};
    logic [63:0]     r;
    logic            o;
    n_if.w_in = 16'sd1; n_if.w_in_valid = 1'b1; tick();
    n_if.w_in_valid = 1'b0; n_if.swap_in = 1'b1; tick();
    idle_n();
    for (int i = 0; i < 4; i++) begin
      r = ref_mac(longint'(signed'(cs[i])), longint'(cd[i]), 1, AW32, o);
      n_if.in_valid = 1'b1; n_if.in_sum = cs[i]; n_if.in_data = DW'(cd[i]);
      tick();
      idle_n();
      tick(); tick();
      total++;
      if (n_if.out_valid !== 1'b1 || n_if.out_sum !== r[AW32-1:0] || n_if.out_ovf !== o) begin bad++;
        $display("FAIL ovf_case%0d got ov=%0h sum=%0h ovf=%0h want 1 %0h %0h", i,
                 n_if.out_valid, n_if.out_sum, n_if.out_ovf, r[AW32-1:0], o); end
    end
  endtask

  task automatic test_random();
    exp_t                 q[$];
    exp_t                 last;
    logic signed [DW-1:0] act_m, sh_m, exp_od, exp_wo, rd, wi;
    logic                 exp_odv, exp_wov, exp_so, exp_ov, en, iv, wv, sw, o;
    logic signed [AW-1:0] rs;
    logic [63:0]          r64, r;
    int                   en_cnt;
    act_m = '0; sh_m = '0; exp_od = '0; exp_wo = '0;
    exp_odv = 0; exp_wov = 0; exp_so = 0; exp_ov = 0; en_cnt = 0;
    last = '{0, '0, 1'b0};
    reset = 1'b1; idle_main(); tick(); reset = 1'b0;
    for (int c = 0; c < 400; c++) begin
      en = ($urandom_range(9, 0) != 0);
      iv = 1'($urandom_range(1, 0));
      rd = DW'($urandom());
      r64 = {$urandom(), $urandom()};
      rs = r64[AW-1:0];
      if ($urandom_range(3, 0) == 0) rs = {1'b0, {(AW-1){1'b1}}} - AW'($urandom_range(1000, 0));
      wv = ($urandom_range(4, 0) == 0);
      wi = DW'($urandom());
      sw = ($urandom_range(7, 0) == 0);
      d_if.enable = en; d_if.in_valid = iv; d_if.in_data = rd; d_if.in_sum = rs;
      d_if.w_in_valid = wv; d_if.w_in = wi; d_if.swap_in = sw;
      if (en) begin
        en_cnt++;
        if (iv) begin
          r = ref_mac(longint'(rs), longint'(rd), longint'(act_m), AW, o);
          q.push_back('{en_cnt, r[AW-1:0], o});
        end
        exp_od = rd; exp_odv = iv; exp_wov = wv; exp_so = sw;
        if (wv) exp_wo = sh_m;
        if (sw) act_m = sh_m;
        if (wv) sh_m = wi;
      end
      tick();
      if (en) begin
        exp_ov = (q.size() != 0 && q[0].issue + LAT - 1 == en_cnt);
        if (exp_ov) last = q.pop_front();
      end
      total++;
      if (d_if.out_valid !== exp_ov) begin bad++;
        $display("FAIL rnd_valid c%0d got %0h want %0h", c, d_if.out_valid, exp_ov); end
      if (exp_ov) begin
        total++;
        if (d_if.out_sum !== last.sum || d_if.out_ovf !== last.ovf) begin bad++;
          $display("FAIL rnd_sum c%0d got %0h/%0h want %0h/%0h", c, d_if.out_sum, d_if.out_ovf, last.sum, last.ovf); end
      end
      total++;
      if (d_if.out_data !== exp_od || d_if.out_dvalid !== exp_odv || d_if.w_out_valid !== exp_wov ||
          d_if.w_out !== exp_wo || d_if.swap_out !== exp_so) begin
        bad++;
        $display("FAIL rnd_side c%0d got d=%0h dv=%0h wv=%0h w=%0h so=%0h want %0h %0h %0h %0h %0h", c,
                 d_if.out_data, d_if.out_dvalid, d_if.w_out_valid, d_if.w_out, d_if.swap_out,
                 exp_od, exp_odv, exp_wov, exp_wo, exp_so);
      end
    end
    idle_main();
  endtask

  task automatic test_reset_inflight();
    idle_main();
    d_if.w_in = 16'sd5; d_if.w_in_valid = 1'b1; tick();
    d_if.w_in_valid = 1'b0; d_if.swap_in = 1'b1; tick();
    d_if.swap_in = 1'b0;
    d_if.in_valid = 1'b1; d_if.in_data = 16'sd2; tick();
    d_if.in_data = 16'sd3; tick();
    idle_main();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (d_if.out_valid !== 1'b0 || d_if.out_dvalid !== 1'b0 || d_if.out_sum !== '0) begin bad++;
      $display("FAIL rif_clear got ov=%0h dv=%0h sum=%0h want 0 0 0", d_if.out_valid, d_if.out_dvalid, d_if.out_sum); end
    for (int c = 0; c < 5; c++) begin
      tick();
      total++; if (d_if.out_valid !== 1'b0) begin bad++; $display("FAIL rif_stale t%0d got ov=%0h want 0", c, d_if.out_valid); end
    end
    d_if.in_valid = 1'b1; d_if.in_data = 16'sd7; d_if.in_sum = 40'sd11;
    d_if.w_in_valid = 1'b1; d_if.w_in = 16'sd4;
    tick();
    idle_main();
    total++; if (d_if.w_out_valid !== 1'b1 || d_if.w_out !== 16'sd0) begin bad++;
      $display("FAIL rif_shadow got v=%0h w=%0h want 1 0", d_if.w_out_valid, d_if.w_out); end
    tick(); tick();
    total++; if (d_if.out_valid !== 1'b1 || d_if.out_sum !== 40'sd11) begin bad++;
      $display("FAIL rif_active got ov=%0h sum=%0d want 1 11", d_if.out_valid, d_if.out_sum); end
  endtask

  initial begin
    idle_main();
    idle_n();
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_chain();
    test_overflow();
    test_random();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
